// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALU select codes,
// select width, lock-state encoding and the requester-id width helper.
package alu_pkg;

  localparam int ALU_SEL_W = 4;

  localparam logic [ALU_SEL_W-1:0] ALU_ADD = 4'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SUB = 4'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_LUI = 4'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SLL = 4'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SRL = 4'd4;
  localparam logic [ALU_SEL_W-1:0] ALU_SRA = 4'd5;
  localparam logic [ALU_SEL_W-1:0] ALU_XOR = 4'd6;
  localparam logic [ALU_SEL_W-1:0] ALU_OR  = 4'd7;
  localparam logic [ALU_SEL_W-1:0] ALU_AND = 4'd8;
  localparam logic [ALU_SEL_W-1:0] ALU_SLT = 4'd9;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index after
// the last-granted one, wrapping modulo N.
module rr_arbiter #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           any
);

  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int off = 1; off <= N; off++) begin
      idx = (int'(last) + off) % N;
      if (!any && req[idx]) begin
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Two-stage controller sharing one ALU between NUM_REQ requesters.
// Optional grant locking is built when the macro ALU_LOCK_EN is defined.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int XLEN    = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*XLEN-1:0]        req_op1,
  input  logic [NUM_REQ*XLEN-1:0]        req_op2,
  input  logic [NUM_REQ*ALU_SEL_W-1:0]   req_sel,
  input  logic [NUM_REQ-1:0]             req_lock,
  output logic [XLEN-1:0]                alu_op1,
  output logic [XLEN-1:0]                alu_op2,
  output logic [ALU_SEL_W-1:0]           alu_sel,
  input  logic [XLEN-1:0]                alu_res,
  input  logic                           alu_zero,
  input  logic                           alu_neg,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [XLEN-1:0]                resp_res,
  output logic                           resp_zero,
  output logic                           resp_neg
);

  localparam int IDW = id_width(NUM_REQ);

  // Handshake: a request transfers on an edge where req_valid[i] & req_ready[i];
  // req_ready is at most one-hot and is never asserted during flush or reset.
  logic [IDW-1:0]     rr_ptr;
  logic               issue_vld;
  logic [IDW-1:0]     issue_id;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     gid;
  logic               any;
  logic               accept;

  rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_arb (
    .req      (eligible),
    .last     (rr_ptr),
    .grant    (grant),
    .grant_id (gid),
    .any      (any)
  );

  assign req_ready = (any && !flush && !rst) ? grant : '0;
  assign accept    = |req_ready;

`ifdef ALU_LOCK_EN
  lock_state_t    lock_state, lock_next;
  logic [IDW-1:0] owner, owner_next;

  // While locked, only the owner may win, even if it is not the RR choice.
  assign eligible = (lock_state == LOCKED)
                  ? (req_valid & (NUM_REQ'(1) << owner)) : req_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= UNLOCKED;
      owner      <= '0;
    end else begin
      lock_state <= lock_next;
      owner      <= owner_next;
    end
  end

  always_comb begin
    lock_next  = lock_state;
    owner_next = owner;
    if (flush) begin
      lock_next = UNLOCKED;
    end else begin
      case (lock_state)
        UNLOCKED: if (accept && req_lock[gid]) begin
          lock_next  = LOCKED;
          owner_next = gid;
        end
        LOCKED: begin
          if (!req_valid[owner])                 lock_next = UNLOCKED;
          else if (accept && !req_lock[gid])     lock_next = UNLOCKED;
        end
        default: lock_next = UNLOCKED;
      endcase
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign eligible    = req_valid;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr     <= '0;
      issue_vld  <= 1'b0;
      issue_id   <= '0;
      alu_op1    <= '0;
      alu_op2    <= '0;
      alu_sel    <= '0;
      resp_valid <= '0;
      resp_res   <= '0;
      resp_zero  <= 1'b0;
      resp_neg   <= 1'b0;
    end else begin
      issue_vld <= accept;
      if (accept) begin
        alu_op1  <= req_op1[int'(gid)*XLEN +: XLEN];
        alu_op2  <= req_op2[int'(gid)*XLEN +: XLEN];
        alu_sel  <= req_sel[int'(gid)*ALU_SEL_W +: ALU_SEL_W];
        issue_id <= gid;
        rr_ptr   <= gid;
      end
      // A flush in the resolution cycle kills the op; resp_* keep old values.
      if (issue_vld && !flush) begin
        resp_valid <= NUM_REQ'(1) << issue_id;
        resp_res   <= alu_res;
        resp_zero  <= alu_zero;
        resp_neg   <= alu_neg;
      end else begin
        resp_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized and directed bench for alu_share_ctrl with a transaction-level
// reference model (grant order, expected-response queue, held response values).
module tb_alu_share_ctrl;
  import alu_pkg::*;

  localparam int N  = 3;
  localparam int XL = 32;
  localparam int EW = 8 + 1 + 1 + XL;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*XL-1:0]   req_op1;
  logic [N*XL-1:0]   req_op2;
  logic [N*4-1:0]    req_sel;
  logic [N-1:0]      req_lock;
  logic [XL-1:0]     alu_op1, alu_op2, alu_res, alu_diff;
  logic [3:0]        alu_sel;
  logic              alu_zero, alu_neg;
  logic [N-1:0]      resp_valid;
  logic [XL-1:0]     resp_res;
  logic              resp_zero, resp_neg;

  alu_share_ctrl #(.NUM_REQ(N), .XLEN(XL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_sel(req_sel), .req_lock(req_lock),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_zero(alu_zero), .alu_neg(alu_neg),
    .resp_valid(resp_valid), .resp_res(resp_res),
    .resp_zero(resp_zero), .resp_neg(resp_neg)
  );

  always #5 clk = ~clk;

  function automatic logic [XL-1:0] alu_f(input logic [XL-1:0] a, input logic [XL-1:0] b,
                                          input logic [3:0] s);
    case (s)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_LUI: return b;
      ALU_SLL: return a << b[4:0];
      ALU_SRL: return a >> b[4:0];
      ALU_SRA: return $unsigned($signed(a) >>> b[4:0]);
      ALU_XOR: return a ^ b;
      ALU_OR:  return a | b;
      ALU_AND: return a & b;
      ALU_SLT: return {31'b0, $signed(a) < $signed(b)};
      default: return '0;
    endcase
  endfunction

  // Environment ALU, fed by the controller's issue registers
  assign alu_res  = alu_f(alu_op1, alu_op2, alu_sel);
  assign alu_zero = (alu_op1 == alu_op2);
  assign alu_diff = alu_op1 - alu_op2;
  assign alu_neg  = alu_diff[XL-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  logic [EW-1:0] exp_q[$];
  int            m_rr;
  bit            m_locked;
  int            m_owner;
  logic [N-1:0]  exp_valid;
  logic [XL-1:0] exp_res;
  logic          exp_zero, exp_neg;
  logic [N-1:0]  obs_ready;

  task automatic model_reset();
    exp_q.delete();
    m_rr = 0; m_locked = 0; m_owner = 0;
    exp_valid = '0; exp_res = '0; exp_zero = 1'b0; exp_neg = 1'b0;
  endtask

  function automatic int model_grant();
    logic [N-1:0] elig;
    int idx;
    elig = req_valid;
`ifdef ALU_LOCK_EN
    if (m_locked) elig = req_valid & (N'(1) << m_owner);
`endif
    for (int off = 1; off <= N; off++) begin
      idx = (m_rr + off) % N;
      if (elig[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clear_all();
    req_valid = '0; req_lock = '0; flush = 1'b0;
    req_op1 = '0; req_op2 = '0; req_sel = '0;
  endtask

  task automatic set_req(input int i, input bit v, input logic [XL-1:0] a,
                         input logic [XL-1:0] b, input logic [3:0] s, input bit lk);
    req_valid[i]       = v;
    req_op1[i*XL +: XL] = a;
    req_op2[i*XL +: XL] = b;
    req_sel[i*4 +: 4]   = s;
    req_lock[i]        = lk;
  endtask

  // One clock cycle: check the grant, cross the edge, check the response.
  task automatic step();
    int g;
    logic [N-1:0]  exp_ready;
    logic [EW-1:0] e;
    logic [XL-1:0] a, b, d;
    #1;
    g = model_grant();
    exp_ready = (g >= 0 && !flush) ? (N'(1) << g) : '0;
    obs_ready = req_ready;
    check("req_ready", req_ready, exp_ready);
    @(posedge clk);
    exp_valid = '0;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (!flush) begin
        exp_valid = N'(1) << e[EW-1 -: 8];
        exp_zero  = e[XL+1];
        exp_neg   = e[XL];
        exp_res   = e[XL-1:0];
      end
    end
    if (exp_ready != '0) begin
      a = req_op1[g*XL +: XL];
      b = req_op2[g*XL +: XL];
      d = a - b;
      exp_q.push_back({8'(g), a == b, d[XL-1], alu_f(a, b, req_sel[g*4 +: 4])});
      m_rr = g;
    end
`ifdef ALU_LOCK_EN
    if (flush) m_locked = 0;
    else if (!m_locked) begin
      if (exp_ready != '0 && req_lock[g]) begin m_locked = 1; m_owner = g; end
    end
    else if (!req_valid[m_owner]) m_locked = 0;
    else if (exp_ready != '0 && !req_lock[g]) m_locked = 0;
`endif
    #1;
    check("resp_valid", resp_valid, exp_valid);
    check("resp_res", resp_res, exp_res);
    check("resp_zero", resp_zero, exp_zero);
    check("resp_neg", resp_neg, exp_neg);
  endtask

  logic [N-1:0] seq_exp[4];

  initial begin
    rst = 1'b1;
    clear_all();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", req_ready, '0);
    check("reset_resp_valid", resp_valid, '0);
    check("reset_alu_op1", alu_op1, '0);
    check("reset_alu_sel", alu_sel, '0);
    @(negedge clk);
    rst = 1'b0;

    // Reset while an op is in flight
    set_req(0, 1, 32'd1, 32'd2, ALU_ADD, 0);
    step();
    #2 rst = 1'b1;
    #1;
    check("midrst_ready", req_ready, '0);
    check("midrst_resp_valid", resp_valid, '0);
    check("midrst_resp_res", resp_res, '0);
    check("midrst_alu_op1", alu_op1, '0);
    check("midrst_alu_op2", alu_op2, '0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_all();
    step();
    step();

    // Single op: 6 + 5
    set_req(0, 1, 32'd6, 32'd5, ALU_ADD, 0);
    step();
    clear_all();
    step();
    check("add_valid", resp_valid, 3'b001);
    check("add_res", resp_res, 32'd11);
    check("add_flags", {resp_zero, resp_neg}, 2'b00);

    // Contention between req0 and req1 from rr_ptr=0
    seq_exp = '{3'b010, 3'b001, 3'b010, 3'b001};
    for (int j = 0; j < 4; j++) begin
      set_req(0, 1, $urandom, $urandom, ALU_XOR, 0);
      set_req(1, 1, $urandom, $urandom, ALU_OR, 0);
      step();
      check("contention_grant", obs_ready, seq_exp[j]);
    end
    clear_all();
    step();

    // Flag cases
    set_req(1, 1, 32'd5, 32'd5, ALU_SUB, 0);
    step();
    set_req(1, 1, 32'd3, 32'd7, ALU_SUB, 0);
    step();
    check("sub_zero_res", resp_res, 32'd0);
    check("sub_zero_flag", resp_zero, 1'b1);
    clear_all();
    step();
    check("sub_neg_res", resp_res, 32'hFFFF_FFFC);
    check("sub_neg_flag", {resp_zero, resp_neg}, 2'b01);

    // Flush kills the op in its resolution cycle
    set_req(0, 1, 32'h8000_0000, 32'd4, ALU_SRA, 0);
    step();
    clear_all();
    flush = 1'b1;
    set_req(1, 1, 32'd9, 32'd9, ALU_ADD, 0);
    step();
    check("flush_ready", obs_ready, '0);
    check("flush_resp_valid", resp_valid, '0);
    clear_all();
    step();
    check("after_flush_valid", resp_valid, '0);

    // Lock: req0 asks to keep the grant for its following ops
    set_req(1, 1, 32'd1, 32'd1, ALU_AND, 0);
    step();
    clear_all();
`ifdef ALU_LOCK_EN
    seq_exp = '{3'b001, 3'b001, 3'b001, 3'b010};
`else
    seq_exp = '{3'b001, 3'b010, 3'b001, 3'b010};
`endif
    for (int j = 0; j < 4; j++) begin
      set_req(0, 1, $urandom, $urandom, ALU_ADD, j < 2);
      set_req(1, 1, $urandom, $urandom, ALU_SUB, 0);
      step();
      check("lock_grant", obs_ready, seq_exp[j]);
    end
    clear_all();
    step();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        logic [XL-1:0] a;
        a = $urandom;
        set_req(i, $urandom_range(0, 3) != 0, a,
                ($urandom_range(0, 3) == 0) ? a : XL'($urandom),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end
      flush = ($urandom_range(0, 7) == 0);
      step();
    end
    clear_all();
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
